// File: rtl/mux2_pkg.sv
// Shared types for the two-input stream arbiter.
//   src_e  : identifies a source (A or B); used for the mux select, the output tag and
//            the round-robin pointer.
//   slot_e : occupancy of the single-entry output register.
package mux2_pkg;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_e;

endpackage

// File: rtl/mux2_bus.sv
// Combinational WIDTH-bit 2-to-1 multiplexer.
//   sel_i : 0 selects a_i, 1 selects b_i
//   a_i   : input word A
//   b_i   : input word B
//   y_o   : selected word
module mux2_bus #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux2_stream_arb.sv
// Two-input valid/ready stream arbiter with a registered output slot.
// Round-robin under contention, one-cycle latency, one word per clock sustained.
//   clk_i              : clock, all state on the rising edge
//   reset_i            : synchronous, active-high reset
//   a_valid_i/a_data_i : source A stream, a_ready_o accepts it
//   b_valid_i/b_data_i : source B stream, b_ready_o accepts it
//   s_o                : combinational mux select this cycle (SRC_A / SRC_B)
//   y_valid_o/y_data_o : registered output stream, y_ready_i drains it
//   y_src_o            : source tag of the word held in y_data_o
module mux2_stream_arb
    import mux2_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [WIDTH-1:0] a_data_i,
    input  logic             b_valid_i,
    output logic             b_ready_o,
    input  logic [WIDTH-1:0] b_data_i,
    output src_e             s_o,
    output logic             y_valid_o,
    input  logic             y_ready_i,
    output logic [WIDTH-1:0] y_data_o,
    output src_e             y_src_o
);

    slot_e            slot_q, slot_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    src_e             y_src_q, y_src_d;
    src_e             last_q, last_d;

    src_e             grant;
    logic             grant_valid;
    logic             out_free;
    logic             accept;
    logic [WIDTH-1:0] mux_y;

    mux2_bus #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i (grant),
        .a_i   (a_data_i),
        .b_i   (b_data_i),
        .y_o   (mux_y)
    );

    assign out_free = (slot_q == SlotEmpty) || y_ready_i;

    // Grant and readies. The pointer only matters under contention, so a lone
    // source is never throttled.
    always_comb begin
        grant_valid = 1'b0;
        grant       = last_q;
        unique case ({a_valid_i, b_valid_i})
            2'b11: begin
                grant_valid = 1'b1;
                grant       = (last_q == SRC_A) ? SRC_B : SRC_A;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant       = SRC_A;
            end
            2'b01: begin
                grant_valid = 1'b1;
                grant       = SRC_B;
            end
            default: begin
                grant_valid = 1'b0;
                grant       = last_q;
            end
        endcase
        // During reset the select shows the post-reset pointer and nothing is accepted.
        if (reset_i) begin
            grant_valid = 1'b0;
            grant       = SRC_B;
        end
        s_o       = grant;
        a_ready_o = out_free && grant_valid && (grant == SRC_A);
        b_ready_o = out_free && grant_valid && (grant == SRC_B);
        accept    = (a_valid_i && a_ready_o) || (b_valid_i && b_ready_o);
    end

    // Output slot next state: a new accept wins over a drain, giving no bubble.
    always_comb begin
        slot_d   = slot_q;
        y_data_d = y_data_q;
        y_src_d  = y_src_q;
        last_d   = last_q;
        if (accept) begin
            slot_d   = SlotFull;
            y_data_d = mux_y;
            y_src_d  = grant;
            last_d   = grant;
        end else if (y_ready_i) begin
            slot_d = SlotEmpty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_q   <= SlotEmpty;
            y_data_q <= '0;
            y_src_q  <= SRC_A;
            last_q   <= SRC_B;
        end else begin
            slot_q   <= slot_d;
            y_data_q <= y_data_d;
            y_src_q  <= y_src_d;
            last_q   <= last_d;
        end
    end

    assign y_valid_o = (slot_q == SlotFull);
    assign y_data_o  = y_data_q;
    assign y_src_o   = y_src_q;

endmodule

// File: tb/tb_mux2_stream_arb.sv
module tb_mux2_stream_arb;

    logic       clk;
    logic       reset;
    logic       a_valid, b_valid, y_ready;
    logic       a_ready, b_ready;
    logic [7:0] a_data, b_data, y_data;
    logic       s, y_valid, y_src;

    int n_cmp  = 0;
    int n_fail = 0;

    mux2_stream_arb #(
        .WIDTH (8)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .a_valid_i (a_valid),
        .a_ready_o (a_ready),
        .a_data_i  (a_data),
        .b_valid_i (b_valid),
        .b_ready_o (b_ready),
        .b_data_i  (b_data),
        .s_o       (s),
        .y_valid_o (y_valid),
        .y_ready_i (y_ready),
        .y_data_o  (y_data),
        .y_src_o   (y_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;

        // Reset held two cycles with both sources valid.
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b0;
        a_data = 8'h11; b_data = 8'h22;
        tick();
        tick();
        check("rst_a_ready", {7'd0, a_ready}, 8'd0);
        check("rst_b_ready", {7'd0, b_ready}, 8'd0);
        check("rst_y_valid", {7'd0, y_valid}, 8'd0);
        check("rst_s",       {7'd0, s},       8'd1);
        check("rst_y_data",  y_data,          8'h00);

        // First cycle after reset: A wins contention.
        reset = 1'b0; y_ready = 1'b1;
        #1;
        check("first_a_ready", {7'd0, a_ready}, 8'd1);
        check("first_b_ready", {7'd0, b_ready}, 8'd0);
        check("first_s",       {7'd0, s},       8'd0);

        // Contention: strict alternation A,B,A,B,A,B at full rate.
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
            check("alt_y_valid", {7'd0, y_valid}, 8'd1);
            check("alt_y_data",  y_data,          exp_d);
            check("alt_y_src",   {7'd0, y_src},   (i % 2 == 0) ? 8'd0 : 8'd1);
        end

        // Single source B at full rate: pointer must not throttle it.
        a_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            b_data = 8'(i);
            #1;
            check("single_b_ready", {7'd0, b_ready}, 8'd1);
            tick();
            check("single_y_valid", {7'd0, y_valid}, 8'd1);
            check("single_y_data",  y_data,          8'(i));
            check("single_y_src",   {7'd0, y_src},   8'd1);
        end

        // Load 0x5A from A, then stall with both sources valid.
        b_valid = 1'b0; a_valid = 1'b1; a_data = 8'h5A;
        tick();
        check("bp_load", y_data, 8'h5A);
        y_ready = 1'b0; b_valid = 1'b1; a_data = 8'h33; b_data = 8'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_a_ready", {7'd0, a_ready}, 8'd0);
            check("bp_b_ready", {7'd0, b_ready}, 8'd0);
            check("bp_s_last",  {7'd0, s},       8'd1);
            tick();
            check("bp_y_valid", {7'd0, y_valid}, 8'd1);
            check("bp_y_data",  y_data,          8'h5A);
            check("bp_y_src",   {7'd0, y_src},   8'd0);
        end
        // Release: B (not last) loads in the same cycle the old word leaves.
        y_ready = 1'b1;
        #1;
        check("rel_b_ready", {7'd0, b_ready}, 8'd1);
        check("rel_a_ready", {7'd0, a_ready}, 8'd0);
        tick();
        check("rel_y_valid", {7'd0, y_valid}, 8'd1);
        check("rel_y_data",  y_data,          8'h44);
        check("rel_y_src",   {7'd0, y_src},   8'd1);

        // Drain: valids low, word leaves, select holds last (B).
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check("drain_s_pre", {7'd0, s}, 8'd1);
        tick();
        check("drain_y_valid", {7'd0, y_valid}, 8'd0);
        check("drain_s",       {7'd0, s},       8'd1);
        check("drain_y_data",  y_data,          8'h44);

        // Reset mid-stall: load 0x77 from A, stall, then reset.
        a_valid = 1'b1; a_data = 8'h77; y_ready = 1'b0;
        tick();
        check("rs_load", y_data, 8'h77);
        a_valid = 1'b0;
        tick();
        check("rs_hold", {7'd0, y_valid}, 8'd1);
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h99; b_data = 8'hAA;
        #1;
        check("rs_a_ready", {7'd0, a_ready}, 8'd0);
        check("rs_b_ready", {7'd0, b_ready}, 8'd0);
        check("rs_s",       {7'd0, s},       8'd1);
        tick();
        reset = 1'b0;
        #1;
        check("rs_y_valid", {7'd0, y_valid}, 8'd0);
        check("rs_y_data",  y_data,          8'h00);
        check("rs_a_wins",  {7'd0, a_ready}, 8'd1);
        check("rs_s_a",     {7'd0, s},       8'd0);
        tick();
        check("rs_post_data", y_data,          8'h99);
        check("rs_post_src",  {7'd0, y_src},   8'd0);
        check("rs_post_vld",  {7'd0, y_valid}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_stream_arb.md
# mux2_stream_arb

Two-input stream arbiter that generates the select for a 2-to-1 data mux and registers the result. Sits directly upstream of the consuming stage: it chooses between two valid/ready sources with round-robin fairness, drives the mux select, and presents the chosen word on a single registered output stream. Latency is one cycle and sustained throughput is one word per clock.

## Interface
- WIDTH, 8, data width of every stream
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- a_valid  in  1  source A offers a_data
- a_ready  out  1  source A word accepted this cycle when a_valid && a_ready
- a_data  in  WIDTH  source A payload
- b_valid  in  1  source B offers b_data
- b_ready  out  1  source B word accepted this cycle when b_valid && b_ready
- b_data  in  WIDTH  source B payload
- s  out  1  combinational mux select this cycle (0 = A, 1 = B)
- y_valid  out  1  output register holds a word
- y_ready  in  1  downstream accepts when y_valid && y_ready
- y_data  out  WIDTH  registered selected payload
- y_src  out  1  source of the word in y_data (0 = A, 1 = B)

One clock; reset is synchronous and active-high.

## Operation
- Output slot state: EMPTY (y_valid=0) or FULL (y_valid=1).
- out_free = !y_valid || y_ready. No load is possible when out_free=0.
- last: 1-bit round-robin pointer holding the source of the most recent accepted word.
- Grant, evaluated combinationally each cycle:
  - Only A valid: A.
  - Only B valid: B.
  - Both valid: the source != last.
  - Neither valid: hold s at last; no grant.
- a_ready = out_free && grant==A. b_ready = out_free && grant==B. At most one ready is high.
- Ready may depend on valid and y_ready. Valid never depends on ready.
- On acceptance:
  - y_data <= mux(s, a_data, b_data).
  - y_src <= s.
  - last <= s.
  - y_valid <= 1.
- If y_ready is high with no new acceptance, y_valid <= 0. y_data and y_src hold their stale values.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with y_ready (back-to-back).
  - FULL→EMPTY on y_ready with no accept.
  - FULL holds while y_ready=0. y_data and y_src stay stable, and both readies are 0.
- last changes only on acceptance, never on stall or idle.

## Timing
- Reset values:
  - y_valid=0, y_data=0, y_src=0.
  - last=1, so A wins the first contention.
  - a_ready=b_ready=0 while reset is high.
  - s=1 during reset, following last.
- Latency: a word accepted at edge N appears with y_valid=1 after edge N.
- Throughput: one word per cycle while y_ready=1, whether from one source or alternating sources.
- Simultaneous y_ready and new accept in the same cycle: the old word leaves and the new word loads, with no bubble.
- Reset mid-operation: the held output word is discarded. y_valid=0 on the next cycle and last returns to 1. No ready is asserted in the reset cycle.
- Single active source is never throttled by the pointer. Fairness applies only under contention: strict A/B alternation.

## Structure
- Package mux2_pkg: src_e typedef (SRC_A=1'b0, SRC_B=1'b1) used for s, y_src and last.
- Sub-module mux2_bus #(WIDTH): purely combinational WIDTH-bit 2-to-1 mux (sel, a, b → y), instantiated once.
- Arbitration, readies and the output register live in the top module.

## Test plan
- Reset then idle: hold reset 2 cycles with both valids high → readies 0, y_valid 0. First cycle after reset: a_ready=1, s=0.
- Contention alternation: a_data=0x11 and b_data=0x22 both held valid, y_ready=1 for 6 cycles → y_data sequence 0x11,0x22,0x11,0x22,0x11,0x22. y_src alternates 0,1,…
- Single source full rate: only b_valid, data 0x01..0x04 on consecutive cycles, y_ready=1 → outputs 0x01..0x04 on consecutive cycles with no gaps, y_src=1.
- Backpressure: y_valid with y_data=0x5A, y_ready=0 for 3 cycles → y_data stays 0x5A, a_ready=b_ready=0, last unchanged. Releasing y_ready → next word loads in the same cycle.
- Drain: one word accepted, then valids low with y_ready=1 → y_valid falls after one cycle and s holds last.
- Reset mid-stall: FULL with y_ready=0, assert reset 1 cycle → y_valid=0 next cycle. A wins the next contention.
